sc_stream_decoder: RTL

// - Stochastic-to-binary converter: counts the 1s in a unipolar stochastic bitstream over a fixed window of

---
 rtl/sc_pkg.sv | 24 ++
 rtl/sc_window_ctr.sv | 43 ++++
 rtl/sc_stream_decoder.sv | 116 +++++++++++
 3 files changed

// File: rtl/sc_pkg.sv
`default_nettype none
// ============================================================================
// Module  : sc_pkg
// Purpose : Shared types and default constants for the stochastic stream
//           decoder. The default window equals the period of the 8-bit LFSR
//           comparator encoders that produce the decoded streams.
// Ports   : none (package)
// Rev     : 1.0  initial release
// ============================================================================
package sc_pkg;

    // Decoder control states
    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } state_t;

    // Result width, window length (LFSR8 period) and window-counter width
    localparam int SC_N      = 8;
    localparam int SC_WINDOW = 255;
    localparam int SC_WCW    = 8;

endpackage
`default_nettype wire

// File: rtl/sc_window_ctr.sv
`default_nettype none
// ============================================================================
// Module  : sc_window_ctr
// Purpose : Enable-gated window counter. Counts enabled samples and flags the
//           final sample of a window.
// Ports   : TRIG  in  clock, rising edge
//           RESET in  asynchronous active-high reset
//           clr   in  synchronous clear (priority over en)
//           en    in  count enable (one enabled sample)
//           last  out high when the current enabled sample is the WINDOW-th
// Rev     : 1.0  initial release
// ============================================================================
module sc_window_ctr #(
    parameter int WINDOW = 255,
    parameter int WCW    = 8
) (
    input  logic TRIG,
    input  logic RESET,
    input  logic clr,
    input  logic en,
    output logic last
);

    localparam logic [WCW-1:0] LAST_CNT = WCW'(WINDOW - 1);

    logic [WCW-1:0] cnt;

    always_ff @(posedge TRIG or posedge RESET) begin
        if (RESET) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + 1'b1;
        end
    end

    // The owner returns to IDLE on the final sample, which clears the counter
    // on the following edge, so no wrap handling is needed here.
    assign last = (cnt == LAST_CNT) & en;

endmodule
`default_nettype wire

// File: rtl/sc_stream_decoder.sv
`default_nettype none
// ============================================================================
// Module  : sc_stream_decoder
// Purpose : Stochastic-to-binary converter. Counts the 1s of a unipolar
//           stochastic bitstream over WINDOW enabled samples and publishes
//           the count as an N-bit binary value.
// Ports   : TRIG  in      clock, rising edge
//           RESET in      asynchronous active-high reset
//           START in      request a conversion (sampled in IDLE only)
//           CLR   in      synchronous abort of the current conversion
//           IN_EN in      sample qualifier
//           IN    in      stochastic bit
//           OUT   out [N] last completed count, held between conversions
//           VALID out     one-cycle pulse, OUT updated this cycle
//           BUSY  out     high while accumulating
// Rev     : 1.0  initial release
// ============================================================================
module sc_stream_decoder
    import sc_pkg::*;
#(
    parameter int N      = SC_N,
    parameter int WINDOW = SC_WINDOW,
    parameter int WCW    = SC_WCW
) (
    input  logic         TRIG,
    input  logic         RESET,
    input  logic         START,
    input  logic         CLR,
    input  logic         IN_EN,
    input  logic         IN,
    output logic [N-1:0] OUT,
    output logic         VALID,
    output logic         BUSY
);

    state_t         state;
    state_t         state_nxt;
    logic [N-1:0]   acc;
    logic [N-1:0]   acc_nxt;
    logic [N-1:0]   acc_sum;
    logic [N-1:0]   out_nxt;
    logic           valid_nxt;
    logic           ctr_clr;
    logic           ctr_en;
    logic           last;

    // Window counter: held clear while idle; CLR suppresses the enable so
    // that an abort can never also complete the window.
    assign ctr_clr = (state == IDLE) | CLR;
    assign ctr_en  = (state == ACCUM) & IN_EN & ~CLR;

    sc_window_ctr #(
        .WINDOW (WINDOW),
        .WCW    (WCW)
    ) u_window_ctr (
        .TRIG   (TRIG),
        .RESET  (RESET),
        .clr    (ctr_clr),
        .en     (ctr_en),
        .last   (last)
    );

    assign acc_sum = acc + {{(N-1){1'b0}}, IN};
    assign BUSY    = (state == ACCUM);

    always_ff @(posedge TRIG or posedge RESET) begin
        if (RESET) begin
            state <= IDLE;
            acc   <= '0;
            OUT   <= '0;
            VALID <= 1'b0;
        end else begin
            state <= state_nxt;
            acc   <= acc_nxt;
            OUT   <= out_nxt;
            VALID <= valid_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        acc_nxt   = acc;
        out_nxt   = OUT;
        valid_nxt = 1'b0;
        case (state)
            IDLE: begin
                // The START cycle's IN bit is deliberately not counted.
                if (START && !CLR) begin
                    state_nxt = ACCUM;
                    acc_nxt   = '0;
                end
            end
            ACCUM: begin
                if (CLR) begin
                    state_nxt = IDLE;
                    acc_nxt   = '0;
                end else if (IN_EN) begin
                    acc_nxt = acc_sum;
                    if (last) begin
                        // Final sample is folded into the published result.
                        out_nxt   = acc_sum;
                        valid_nxt = 1'b1;
                        state_nxt = IDLE;
                        acc_nxt   = '0;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
                acc_nxt   = '0;
            end
        endcase
    end

endmodule
`default_nettype wire
